// File: rtl/baby_crt_scanner.sv
// baby_crt_scanner
//   Raster controller for the Manchester Baby CRT store display. The 512x512
//   display window shows a 32x32-bit store, one 16x16 pixel cell per bit.
//   One 32-bit store word (a row of cells) is fetched per line, ahead of the
//   line that shows it, through a req/ack port shared with the CPU arbiter.
//   Each pixel selects the "dot on" or "dot off" glyph ROM pixel for its
//   cell.
//
// Ports
//   clk, reset              system clock, synchronous active-high reset
//   pix_en                  pixel clock enable for the pixel pipeline
//   hcount, vcount          raster position (11-bit)
//   de                      display enable from the timing generator
//   line_start              one-cycle pulse at start of hblank of line vcount
//   store_req/addr          store word read request and row index
//   store_ack/data          read done, with data valid in the same cycle
//   dot_x, dot_y            position within the cell, to both glyph ROMs
//   dot_on/off_pixel        combinational ROM outputs
//   pixel_out, de_out       video pixel and matching delayed display enable
//   underrun, underrun_clr  sticky fetch-late flag and its clear
module baby_crt_scanner #(
    parameter int H_ORIGIN = 64,
    parameter int V_ORIGIN = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic        de,
    input  logic        line_start,
    output logic        store_req,
    output logic [4:0]  store_addr,
    input  logic        store_ack,
    input  logic [31:0] store_data,
    output logic [3:0]  dot_x,
    output logic [3:0]  dot_y,
    input  logic        dot_on_pixel,
    input  logic        dot_off_pixel,
    output logic        pixel_out,
    output logic        de_out,
    output logic        underrun,
    input  logic        underrun_clr
);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t      state;
    logic [31:0] line_word;
    logic        line_valid;
    logic [4:0]  pend_addr;
    logic        pend_ok;
    logic        miss_seen;

    logic        bit_s1;
    logic        win_s1;
    logic        de_s1;

    // Window test: subtract the origin with one spare bit so that a position
    // left of / above the origin shows up as a borrow rather than wrapping.
    logic [11:0] hdiff;
    logic [11:0] vdiff;
    logic [12:0] tdiff;
    logic [8:0]  tcell;
    logic        h_in;
    logic        v_in;
    logic        in_win;
    logic [8:0]  lx;
    logic [8:0]  ly;
    logic        t_in;
    logic [4:0]  trow;

    assign hdiff  = {1'b0, hcount} - 12'(H_ORIGIN);
    assign vdiff  = {1'b0, vcount} - 12'(V_ORIGIN);
    assign h_in   = (hdiff[11:9] == 3'b000);
    assign v_in   = (vdiff[11:9] == 3'b000);
    assign in_win = h_in & v_in;
    assign lx     = hdiff[8:0];
    assign ly     = vdiff[8:0];

    // Target line of a fetch is vcount+1, computed wide so the last counter
    // value runs off the bottom of the window instead of wrapping to line 0.
    assign tdiff  = {2'b00, vcount} + 13'd1 - 13'(V_ORIGIN);
    assign tcell  = 9'(tdiff >> 4);
    assign t_in   = (tcell[8:5] == 4'b0000);
    assign trow   = tcell[4:0];

    // A line_start arriving in DISCARD retargets the pending fetch.
    logic [4:0] next_addr;
    logic       next_ok;
    assign next_addr = line_start ? trow : pend_addr;
    assign next_ok   = line_start ? t_in : pend_ok;

    logic fetch_late;
    logic miss_set;
    assign fetch_late = line_start &
                        (((state == REQ) & ~store_ack) | (state == DISCARD));
    assign miss_set   = pix_en & in_win & ~line_valid & ~miss_seen;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            store_req  <= 1'b0;
            store_addr <= '0;
            line_word  <= '0;
            line_valid <= 1'b0;
            pend_addr  <= '0;
            pend_ok    <= 1'b0;
            miss_seen  <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (line_start && t_in) begin
                        state      <= REQ;
                        store_req  <= 1'b1;
                        store_addr <= trow;
                    end
                end
                REQ: begin
                    if (store_ack) begin
                        line_word <= store_data;
                        // A coincident line_start is treated as arriving in
                        // IDLE: the next row's request follows immediately.
                        if (line_start && t_in) begin
                            store_addr <= trow;
                        end else begin
                            state     <= IDLE;
                            store_req <= 1'b0;
                        end
                    end else if (line_start) begin
                        state     <= DISCARD;
                        pend_addr <= trow;
                        pend_ok   <= t_in;
                    end
                end
                DISCARD: begin
                    if (store_ack) begin
                        if (next_ok) begin
                            state      <= REQ;
                            store_addr <= next_addr;
                        end else begin
                            state     <= IDLE;
                            store_req <= 1'b0;
                        end
                    end else begin
                        pend_addr <= next_addr;
                        pend_ok   <= next_ok;
                    end
                end
                default: begin
                    state     <= IDLE;
                    store_req <= 1'b0;
                end
            endcase

            if (line_start)
                line_valid <= 1'b0;
            else if (state == REQ && store_ack)
                line_valid <= 1'b1;

            miss_seen <= line_start ? 1'b0 : (miss_seen | miss_set);
            underrun  <= fetch_late | miss_set | (underrun & ~underrun_clr);
        end
    end

    // Two-stage pixel pipeline: stage 1 addresses the glyph ROMs, stage 2
    // registers the selected ROM pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            dot_x     <= '0;
            dot_y     <= '0;
            bit_s1    <= 1'b0;
            win_s1    <= 1'b0;
            de_s1     <= 1'b0;
            pixel_out <= 1'b0;
            de_out    <= 1'b0;
        end else if (pix_en) begin
            dot_x     <= lx[3:0];
            dot_y     <= ly[3:0];
            bit_s1    <= line_word[lx[8:4]];
            win_s1    <= in_win & line_valid & de;
            de_s1     <= de;
            pixel_out <= win_s1 ? (bit_s1 ? dot_on_pixel : dot_off_pixel) : 1'b0;
            de_out    <= de_s1;
        end
    end

endmodule

// File: tb/tb_baby_crt_scanner.sv
module tb_baby_crt_scanner;

    localparam int H0 = 64;
    localparam int V0 = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_en = 1'b0;
    logic [10:0] hcount = '0;
    logic [10:0] vcount = '0;
    logic        de = 1'b0;
    logic        line_start = 1'b0;
    logic        store_req;
    logic [4:0]  store_addr;
    logic        store_ack = 1'b0;
    logic [31:0] store_data = '0;
    logic [3:0]  dot_x;
    logic [3:0]  dot_y;
    logic        dot_on_pixel;
    logic        dot_off_pixel;
    logic        pixel_out;
    logic        de_out;
    logic        underrun;
    logic        underrun_clr = 1'b0;

    baby_crt_scanner #(.H_ORIGIN(H0), .V_ORIGIN(V0)) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .hcount(hcount), .vcount(vcount), .de(de), .line_start(line_start),
        .store_req(store_req), .store_addr(store_addr),
        .store_ack(store_ack), .store_data(store_data),
        .dot_x(dot_x), .dot_y(dot_y),
        .dot_on_pixel(dot_on_pixel), .dot_off_pixel(dot_off_pixel),
        .pixel_out(pixel_out), .de_out(de_out),
        .underrun(underrun), .underrun_clr(underrun_clr)
    );

    always #5 clk = ~clk;

    // Glyph ROM stand-ins with distinct patterns.
    function automatic logic on_rom(input logic [3:0] x, input logic [3:0] y);
        return (x == y) | x[2];
    endfunction
    function automatic logic off_rom(input logic [3:0] x, input logic [3:0] y);
        return x[1] ^ y[1];
    endfunction

    assign dot_on_pixel  = on_rom(dot_x, dot_y);
    assign dot_off_pixel = off_rom(dot_x, dot_y);

    typedef struct packed { logic pix; logic de; } exp_t;
    exp_t sb[$];
    exp_t last;

    int nvec = 0;
    int nerr = 0;
    logic        mv = 1'b0;
    logic [31:0] mword = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected pixel for a raster position given the model's line buffer.
    function automatic logic expf(input logic [10:0] h, input logic [10:0] v, input logic d);
        logic [10:0] lx;
        logic [10:0] ly;
        lx = h - 11'(H0);
        ly = v - 11'(V0);
        if (!(h >= 11'(H0) && lx <= 11'd511 && v >= 11'(V0) && ly <= 11'd511 && d && mv))
            return 1'b0;
        return mword[lx[8:4]] ? on_rom(lx[3:0], ly[3:0]) : off_rom(lx[3:0], ly[3:0]);
    endfunction

    task automatic step(input logic [10:0] h, input logic [10:0] v, input logic d,
                        input logic pe, input logic ls, input logic ack,
                        input logic [31:0] data, input logic clr, input logic ex);
        exp_t e;
        hcount = h; vcount = v; de = d; pix_en = pe;
        line_start = ls; store_ack = ack; store_data = data; underrun_clr = clr;
        if (pe) sb.push_back('{ex, d});
        @(posedge clk);
        #1;
        if (pe) begin
            if (sb.size() == 0) begin
                check("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("pixel_out", {31'd0, pixel_out}, {31'd0, e.pix});
                check("de_out", {31'd0, de_out}, {31'd0, e.de});
                last = e;
            end
        end else begin
            check("pixel_frozen", {31'd0, pixel_out}, {31'd0, last.pix});
        end
        line_start = 1'b0; store_ack = 1'b0; underrun_clr = 1'b0;
    endtask

    task automatic idle(input logic [10:0] v, input logic ls, input logic ack,
                        input logic [31:0] data, input logic clr);
        step(11'd0, v, 1'b0, 1'b1, ls, ack, data, clr, 1'b0);
    endtask

    task automatic do_reset(input logic ack);
        reset = 1'b1; store_ack = ack; pix_en = 1'b0; line_start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0; store_ack = 1'b0;
        sb.delete();
        sb.push_back('{1'b0, 1'b0});
        last = '{1'b0, 1'b0};
        mv = 1'b0;
    endtask

    typedef struct {
        logic [10:0] h;
        logic [10:0] v;
        logic        d;
        logic        pe;
        logic        win;
        logic        exp;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(input int h, input int v, input logic d, input logic pe, input logic win);
        vec_t r;
        logic [10:0] x;
        logic [10:0] y;
        r.h = 11'(h); r.v = 11'(v); r.d = d; r.pe = pe; r.win = win;
        x = r.h - 11'(H0);
        y = r.v - 11'(V0);
        r.exp = (win && d) ? on_rom(x[3:0], y[3:0]) : 1'b0;
        return r;
    endfunction

    initial begin
        // Window-edge table, shown with an all-ones word (every cell "dot on").
        tbl.push_back(mk(H0-1,   V0+5,   1, 1, 0));
        tbl.push_back(mk(H0,     V0+5,   1, 1, 1));
        tbl.push_back(mk(H0+1,   V0+5,   1, 1, 1));
        tbl.push_back(mk(H0+3,   V0+5,   1, 1, 1));
        tbl.push_back(mk(H0+4,   V0+5,   1, 1, 1));
        tbl.push_back(mk(H0+5,   V0+5,   1, 1, 1));
        tbl.push_back(mk(300,    V0+5,   1, 0, 0));
        tbl.push_back(mk(301,    V0+5,   1, 0, 0));
        tbl.push_back(mk(H0+511, V0+5,   1, 1, 1));
        tbl.push_back(mk(H0+512, V0+5,   1, 1, 0));
        tbl.push_back(mk(2047,   V0+5,   1, 1, 0));
        tbl.push_back(mk(100,    V0+5,   0, 1, 0));
        tbl.push_back(mk(H0,     V0-1,   1, 1, 0));
        tbl.push_back(mk(H0,     V0+511, 1, 1, 1));
        tbl.push_back(mk(100,    V0+512, 1, 1, 0));

        repeat (2) @(posedge clk);
        #1;
        do_reset(1'b0);
        check("rst_store_req", {31'd0, store_req}, 32'd0);
        check("rst_store_addr", {27'd0, store_addr}, 32'd0);
        check("rst_pixel_out", {31'd0, pixel_out}, 32'd0);
        check("rst_de_out", {31'd0, de_out}, 32'd0);
        check("rst_underrun", {31'd0, underrun}, 32'd0);
        check("rst_dot_x", {28'd0, dot_x}, 32'd0);

        // Reset in the middle of a request, with an ack pending.
        idle(11'(V0-1), 1, 0, 0, 0);
        check("req_before_reset", {31'd0, store_req}, 32'd1);
        do_reset(1'b1);
        check("req_dropped_by_reset", {31'd0, store_req}, 32'd0);
        check("underrun_after_reset", {31'd0, underrun}, 32'd0);
        idle(11'(V0-1), 0, 1, 32'hFFFF_FFFF, 0);
        check("late_ack_no_req", {31'd0, store_req}, 32'd0);
        step(11'(H0), 11'(V0+3), 1, 1, 0, 0, 0, 0, expf(11'(H0), 11'(V0+3), 1));
        check("stale_ack_ignored_underrun", {31'd0, underrun}, 32'd1);
        idle(11'(V0+3), 0, 0, 0, 0);
        idle(11'(V0+3), 0, 0, 0, 1);
        check("underrun_cleared", {31'd0, underrun}, 32'd0);

        // First line of the window: row 0, word 1 (cell 0 on, cell 1 off).
        idle(11'(V0-1), 1, 0, 0, 0);
        check("fetch_row0_req", {31'd0, store_req}, 32'd1);
        check("fetch_row0_addr", {27'd0, store_addr}, 32'd0);
        idle(11'(V0-1), 0, 0, 0, 0);
        idle(11'(V0-1), 0, 0, 0, 0);
        check("req_held", {31'd0, store_req}, 32'd1);
        check("addr_held", {27'd0, store_addr}, 32'd0);
        idle(11'(V0-1), 0, 1, 32'h0000_0001, 0);
        check("req_done", {31'd0, store_req}, 32'd0);
        mv = 1'b1; mword = 32'h0000_0001;
        for (int h = H0; h < H0 + 32; h++) begin
            step(11'(h), 11'(V0+3), 1, 1, 0, 0, 0, 0, expf(11'(h), 11'(V0+3), 1));
            if (h == H0) begin
                check("dot_y_line3", {28'd0, dot_y}, 32'd3);
                check("dot_x_first", {28'd0, dot_x}, 32'd0);
            end
        end
        idle(11'(V0+3), 0, 0, 0, 0);
        idle(11'(V0+3), 0, 0, 0, 0);
        check("no_underrun_on_time", {31'd0, underrun}, 32'd0);

        // Window edges and pix_en freeze.
        idle(11'(V0+4), 1, 0, 0, 0);
        idle(11'(V0+4), 0, 1, 32'hFFFF_FFFF, 0);
        mv = 1'b1; mword = 32'hFFFF_FFFF;
        foreach (tbl[i])
            step(tbl[i].h, tbl[i].v, tbl[i].d, tbl[i].pe, 0, 0, 0, 0, tbl[i].exp);
        idle(11'(V0+5), 0, 0, 0, 0);
        idle(11'(V0+5), 0, 0, 0, 0);

        // Row addressing and bottom-edge / wrap suppression.
        idle(11'(V0+31), 1, 0, 0, 0);
        mv = 1'b0;
        check("row2_addr", {27'd0, store_addr}, 32'd2);
        check("row2_req", {31'd0, store_req}, 32'd1);
        idle(11'(V0+31), 0, 1, 32'h0, 0);
        idle(11'(V0+511), 1, 0, 0, 0);
        check("bottom_no_req", {31'd0, store_req}, 32'd0);
        idle(11'(V0+511), 0, 0, 0, 0);
        check("bottom_no_req_later", {31'd0, store_req}, 32'd0);
        idle(11'd2047, 1, 0, 0, 0);
        check("wrap_no_req", {31'd0, store_req}, 32'd0);

        // Ack withheld past the window start.
        idle(11'(V0+14), 1, 0, 0, 0);
        check("late_row_addr", {27'd0, store_addr}, 32'd0);
        for (int h = H0; h < H0 + 4; h++) begin
            step(11'(h), 11'(V0+15), 1, 1, 0, 0, 0, 0, expf(11'(h), 11'(V0+15), 1));
            if (h == H0) check("underrun_on_late_fetch", {31'd0, underrun}, 32'd1);
        end
        step(11'(H0+4), 11'(V0+15), 1, 1, 0, 1, 32'h0000_0001, 0, expf(11'(H0+4), 11'(V0+15), 1));
        mv = 1'b1; mword = 32'h0000_0001;
        for (int h = H0 + 5; h < H0 + 12; h++)
            step(11'(h), 11'(V0+15), 1, 1, 0, 0, 0, 0, expf(11'(h), 11'(V0+15), 1));
        check("late_ack_req_done", {31'd0, store_req}, 32'd0);
        idle(11'(V0+15), 0, 0, 0, 0);
        idle(11'(V0+15), 0, 0, 0, 1);
        check("underrun_clr", {31'd0, underrun}, 32'd0);

        // Second line_start while in REQ: set+clear together, discard, reissue.
        idle(11'(V0+24), 1, 0, 0, 0);
        mv = 1'b0;
        check("discard_first_addr", {27'd0, store_addr}, 32'd1);
        idle(11'(V0+44), 1, 0, 0, 1);
        check("set_beats_clr", {31'd0, underrun}, 32'd1);
        check("discard_req_held", {31'd0, store_req}, 32'd1);
        check("discard_addr_held", {27'd0, store_addr}, 32'd1);
        idle(11'(V0+44), 0, 1, 32'h0000_0001, 0);
        check("reissue_req", {31'd0, store_req}, 32'd1);
        check("reissue_addr", {27'd0, store_addr}, 32'd2);
        idle(11'(V0+44), 0, 1, 32'h0000_0002, 0);
        check("reissue_done", {31'd0, store_req}, 32'd0);
        mv = 1'b1; mword = 32'h0000_0002;
        for (int k = 0; k < 4; k++) begin
            int h;
            h = (k < 2) ? (H0 + k) : (H0 + 14 + k);
            step(11'(h), 11'(V0+45), 1, 1, 0, 0, 0, 0, expf(11'(h), 11'(V0+45), 1));
        end
        idle(11'(V0+45), 0, 0, 0, 0);
        idle(11'(V0+45), 0, 0, 0, 0);
        check("underrun_sticky", {31'd0, underrun}, 32'd1);

        // line_start coincident with ack in REQ: data kept, next fetch follows.
        idle(11'(V0+45), 0, 0, 0, 1);
        check("underrun_clr2", {31'd0, underrun}, 32'd0);
        idle(11'(V0+44), 1, 0, 0, 0);
        mv = 1'b0;
        idle(11'(V0+60), 1, 1, 32'h0000_0001, 0);
        check("coincident_req", {31'd0, store_req}, 32'd1);
        check("coincident_addr", {27'd0, store_addr}, 32'd3);
        check("coincident_no_underrun", {31'd0, underrun}, 32'd0);
        idle(11'(V0+60), 0, 1, 32'h0000_0000, 0);
        check("coincident_done", {31'd0, store_req}, 32'd0);
        mv = 1'b1; mword = 32'h0000_0000;
        for (int h = H0; h < H0 + 4; h++)
            step(11'(h), 11'(V0+61), 1, 1, 0, 0, 0, 0, expf(11'(h), 11'(V0+61), 1));
        idle(11'(V0+61), 0, 0, 0, 0);
        idle(11'(V0+61), 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
